// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit.
// Holds the br_op encodings, the 2-bit counter states and the saturating update.
package branch_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b010;
  localparam logic [2:0] BR_BNE  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTS = 3'b101;
  localparam logic [2:0] BR_BGES = 3'b110;
  localparam logic [2:0] BR_JMP  = 3'b111;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Move one step towards the resolved direction, sticking at either end.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != CNT_ST)
      nxt = cnt + 2'd1;
    else if (!taken && cnt != CNT_SNT)
      nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Bimodal predictor: DEPTH 2-bit saturating counters, combinational lookup
// for fetch and a single registered update port from branch resolution.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDXW-1:0] lk_idx,
  output logic            lk_taken,
  input  logic            upd_en,
  input  logic [IDXW-1:0] upd_idx,
  input  logic            upd_taken
);

  logic [1:0] cnt [DEPTH];

  // NOTE: this array is reset on purpose -- every entry must come up weakly
  // not-taken, so it lives in flops rather than an unreset RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        cnt[i] <= CNT_WNT;
    end else if (upd_en) begin
      cnt[upd_idx] <= sat_update(cnt[upd_idx], upd_taken);
    end
  end

  // Lookup sees the pre-edge value when it collides with an update.
  assign lk_taken = cnt[lk_idx][1];

endmodule

// File: rtl/branch_unit.sv
// Branch resolution: condition evaluation, target adder, registered result
// and mispredict flag. Optional counters behind `BRANCH_STATS_EN.
module branch_unit
  import branch_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] lk_pc,
  output logic          lk_taken,
  input  logic          in_valid,
  input  logic          flush,
  input  logic [2:0]    br_op,
  input  logic [DW-1:0] ina,
  input  logic [DW-1:0] inb,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] offset,
  input  logic          pred_taken,
  output logic          out_valid,
  output logic          bj,
  output logic [AW-1:0] target,
  output logic          mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]   stat_branches,
  output logic [31:0]   stat_mispredicts
`endif
);

  localparam int IDXW = $clog2(DEPTH);

  logic acc;
  logic cond;
  logic upd_en;
  logic unused_pc_hi;

  assign acc    = in_valid & ~flush;
  assign upd_en = acc & (br_op != BR_NONE);

  // Only the index bits address the predictor.
  assign unused_pc_hi = ^{lk_pc[AW-1:IDXW], pc[AW-1:IDXW]};

  // NOTE: always_comb gives cond a default before the case, so no path
  // through it can leave cond unassigned and infer a latch.
  always_comb begin
    cond = 1'b0;
    case (br_op)
      BR_BEQ:  cond = (ina == inb);
      BR_BLT:  cond = (ina < inb);
      BR_BNE:  cond = (ina != inb);
      BR_BGE:  cond = (ina >= inb);
      BR_BLTS: cond = ($signed(ina) < $signed(inb));
      BR_BGES: cond = ($signed(ina) >= $signed(inb));
      BR_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  // NOTE: registers use <= so every flop samples the values present before
  // the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      bj         <= 1'b0;
      mispredict <= 1'b0;
      target     <= '0;
    end else begin
      out_valid  <= acc;
      bj         <= acc & cond;
      mispredict <= acc & (cond != pred_taken);
      if (acc)
        target <= pc + offset;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_en)
        stat_branches <= stat_branches + 32'd1;
      if (acc & (cond != pred_taken))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

  branch_predictor #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_pred (
    .clk       (clk),
    .rst       (rst),
    .lk_idx    (lk_pc[IDXW-1:0]),
    .lk_taken  (lk_taken),
    .upd_en    (upd_en),
    .upd_idx   (pc[IDXW-1:0]),
    .upd_taken (cond)
  );

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit (DW=AW=16, DEPTH=16); define BRANCH_STATS_EN
// on both RTL and bench to exercise the statistics counters.
module tb_branch_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lk_pc;
  logic        lk_taken;
  logic        in_valid, flush, pred_taken;
  logic [2:0]  br_op;
  logic [15:0] ina, inb, pc, offset;
  logic        out_valid, bj, mispredict;
  logic [15:0] target;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_unit #(.DW(16), .AW(16), .DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .lk_pc      (lk_pc),
    .lk_taken   (lk_taken),
    .in_valid   (in_valid),
    .flush      (flush),
    .br_op      (br_op),
    .ina        (ina),
    .inb        (inb),
    .pc         (pc),
    .offset     (offset),
    .pred_taken (pred_taken),
    .out_valid  (out_valid),
    .bj         (bj),
    .target     (target),
    .mispredict (mispredict)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] p, input logic [15:0] off, input logic pt,
                       input logic fl);
    in_valid   = 1'b1;
    flush      = fl;
    br_op      = op;
    ina        = a;
    inb        = b;
    pc         = p;
    offset     = off;
    pred_taken = pt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic resolve(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] p, input logic [15:0] off, input logic pt);
    drive(op, a, b, p, off, pt, 1'b0);
    step();
  endtask

  task automatic check_out(input string tag, input logic ov, input logic b,
                           input logic [15:0] t, input logic mp);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, ".bj"}, {31'd0, bj}, {31'd0, b});
    check({tag, ".target"}, {16'd0, target}, {16'd0, t});
    check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, mp});
  endtask

  task automatic check_lk(input string tag, input logic [15:0] p, input logic exp);
    lk_pc = p;
    #1;
    check(tag, {31'd0, lk_taken}, {31'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; lk_pc = '0; in_valid = 1'b0; flush = 1'b0; br_op = BR_NONE;
    ina = '0; inb = '0; pc = '0; offset = '0; pred_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
    check_lk("reset.lk0", 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // BEQ taken, predicted not-taken
    resolve(BR_BEQ, 16'd5, 16'd5, 16'h0010, 16'h0004, 1'b0);
    check_out("beq", 1'b1, 1'b1, 16'h0014, 1'b1);
    @(posedge clk);
    #1;
    check("idle.out_valid", {31'd0, out_valid}, 32'd0);
    check("idle.target_hold", {16'd0, target}, 32'h0014);

    // unsigned vs signed compares on 0xFFFF / 0x0001, idx 8
    resolve(BR_BLT, 16'hFFFF, 16'h0001, 16'h0028, 16'h0002, 1'b0);
    check_out("blt", 1'b1, 1'b0, 16'h002A, 1'b0);
    resolve(BR_BLTS, 16'hFFFF, 16'h0001, 16'h0028, 16'h0002, 1'b0);
    check_out("blts", 1'b1, 1'b1, 16'h002A, 1'b1);
    resolve(BR_BGES, 16'hFFFF, 16'h0001, 16'h0028, 16'h0002, 1'b1);
    check_out("bges", 1'b1, 1'b0, 16'h002A, 1'b1);
    resolve(BR_BGE, 16'hFFFF, 16'h0001, 16'h0028, 16'h0002, 1'b1);
    check_out("bge", 1'b1, 1'b1, 16'h002A, 1'b0);
    resolve(BR_BNE, 16'd3, 16'd4, 16'h0028, 16'hFFFE, 1'b1);
    check_out("bne", 1'b1, 1'b1, 16'h0026, 1'b0);
    resolve(BR_BEQ, 16'd3, 16'd4, 16'h0028, 16'h0000, 1'b0);
    check_out("beq_nt", 1'b1, 1'b0, 16'h0028, 1'b0);

    // BR_NONE must not touch the predictor: idx 5 goes to 10 first
    resolve(BR_JMP, 16'd0, 16'd0, 16'h0005, 16'h0001, 1'b0);
    check_lk("none.pre", 16'h0005, 1'b1);
    resolve(BR_NONE, 16'd0, 16'd0, 16'h0005, 16'h0001, 1'b0);
    check_out("none", 1'b1, 1'b0, 16'h0006, 1'b0);
    check_lk("none.no_upd", 16'h0005, 1'b1);

    // saturation on idx 3, with a same-cycle lookup before the first update
    drive(BR_JMP, 16'd0, 16'd0, 16'h0003, 16'h0000, 1'b0, 1'b0);
    lk_pc = 16'h0003;
    #1;
    check("sat.same_cycle", {31'd0, lk_taken}, 32'd0);
    step();
    check_lk("sat.t1", 16'h0003, 1'b1);
    resolve(BR_JMP, 16'd0, 16'd0, 16'h0003, 16'h0000, 1'b1);
    check_lk("sat.t2", 16'h0003, 1'b1);
    resolve(BR_JMP, 16'd0, 16'd0, 16'h0003, 16'h0000, 1'b1);
    check_lk("sat.t3", 16'h0003, 1'b1);
    // 11 -> 10 -> 01 -> 00 -> 00
    resolve(BR_BNE, 16'd7, 16'd7, 16'h0003, 16'h0000, 1'b1);
    check_lk("sat.n1", 16'h0003, 1'b1);
    resolve(BR_BNE, 16'd7, 16'd7, 16'h0003, 16'h0000, 1'b1);
    check_lk("sat.n2", 16'h0003, 1'b0);
    resolve(BR_BNE, 16'd7, 16'd7, 16'h0003, 16'h0000, 1'b0);
    resolve(BR_BNE, 16'd7, 16'd7, 16'h0003, 16'h0000, 1'b0);
    check_lk("sat.n4", 16'h0003, 1'b0);
    // from 00 a single taken only reaches 01
    resolve(BR_JMP, 16'd0, 16'd0, 16'h0003, 16'h0000, 1'b0);
    check_lk("sat.floor", 16'h0003, 1'b0);

    // flushed JMP: no result, target holds, counter untouched
    resolve(BR_JMP, 16'd0, 16'd0, 16'h0020, 16'h0010, 1'b1);
    check_out("jmp", 1'b1, 1'b1, 16'h0030, 1'b0);
    drive(BR_JMP, 16'd0, 16'd0, 16'h004A, 16'h0100, 1'b0, 1'b1);
    step();
    check_out("flush", 1'b0, 1'b0, 16'h0030, 1'b0);
    check_lk("flush.lk", 16'h004A, 1'b0);
    resolve(BR_JMP, 16'd0, 16'd0, 16'h004A, 16'h0100, 1'b0);
    check_out("unflush", 1'b1, 1'b1, 16'h014A, 1'b1);
    check_lk("unflush.lk", 16'h004A, 1'b1);

    // target wrap
    resolve(BR_JMP, 16'd0, 16'd0, 16'hFFFE, 16'h0004, 1'b1);
    check_out("wrap", 1'b1, 1'b1, 16'h0002, 1'b0);

    // asynchronous reset between edges
    resolve(BR_JMP, 16'd0, 16'd0, 16'h0007, 16'h0009, 1'b0);
    check_out("pre_rst", 1'b1, 1'b1, 16'h0010, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("mid_rst", 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 16; i++)
      check_lk($sformatf("mid_rst.lk%0d", i), 16'(i), 1'b0);
`ifdef BRANCH_STATS_EN
    check("stats.rst_br", stat_branches, 32'd0);
    check("stats.rst_mp", stat_mispredicts, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

`ifdef BRANCH_STATS_EN
    // 10 branches, the first 3 mispredicted; NONE and flushed ones don't count
    for (int i = 0; i < 10; i++) begin
      resolve(BR_JMP, 16'd0, 16'd0, 16'(i), 16'h0000, (i < 3) ? 1'b0 : 1'b1);
      if (i == 4) begin
        resolve(BR_NONE, 16'd0, 16'd0, 16'h0001, 16'h0000, 1'b0);
        drive(BR_JMP, 16'd0, 16'd0, 16'h0001, 16'h0000, 1'b0, 1'b1);
        step();
      end
    end
    check("stats.branches", stat_branches, 32'd10);
    check("stats.mispredicts", stat_mispredicts, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
